// File: rtl/interrupt_controller_if.sv
// Signal bundle between interrupt sources, the CPU interrupt pins and the i/o window
// of interrupt_controller. The controller uses the slave modport.
interface interrupt_controller_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 4
);
    logic [NUM_SRC-1:0] irq_src;
    logic [NUM_SRC-1:0] intr_out;
    logic               int_taken;
    logic               int_eret;
    logic [AW-1:0]      io_addr;
    logic               io_wr;
    logic               io_rd;
    logic [31:0]        io_wdata;
    logic [31:0]        io_rdata;

    modport master (
        output irq_src, int_taken, int_eret, io_addr, io_wr, io_rd, io_wdata,
        input  intr_out, io_rdata
    );

    modport slave (
        input  irq_src, int_taken, int_eret, io_addr, io_wr, io_rd, io_wdata,
        output intr_out, io_rdata
    );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: sync/edge-detect, pending/mask/in-service registers.
// Define INTC_LOST_CNT_EN to add per-source saturating lost-event counters at offset 0xC.
module interrupt_controller #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    interrupt_controller_if.slave bus
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [AW-1:0] ADDR_PENDING = AW'(0);
    localparam logic [AW-1:0] ADDR_MASK    = AW'(4);
    localparam logic [AW-1:0] ADDR_INSVC   = AW'(8);
    localparam logic [AW-1:0] ADDR_LOST    = AW'(12);

    typedef enum logic [1:0] {IDLE, REQ, SVC} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] insvc_q, insvc_d;
    logic [NUM_SRC-1:0] intr_q, intr_d;
    logic [NUM_SRC-1:0] edge_evt, take_clr, w1c_clr, ready;
    logic               wr_pending, wr_mask;
    logic [31:0]        lost_rdata;
    logic               unused_bits;

    assign edge_evt   = sync2_q & ~hist_q;
    assign ready      = pending_q & mask_q;
    assign wr_pending = bus.io_wr && (bus.io_addr == ADDR_PENDING);
    assign wr_mask    = bus.io_wr && (bus.io_addr == ADDR_MASK);
    assign w1c_clr    = wr_pending ? bus.io_wdata[NUM_SRC-1:0] : '0;
    assign mask_d     = wr_mask ? bus.io_wdata[NUM_SRC-1:0] : mask_q;
    assign unused_bits = ^{bus.io_rd, bus.io_wdata};

    // A fresh edge wins over any clear landing on the same bit in the same cycle.
    assign pending_d = (pending_q & ~(w1c_clr | take_clr)) | edge_evt;
    assign bus.intr_out = intr_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        intr_d   = intr_q;
        insvc_d  = insvc_q;
        take_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (|ready) begin
                    for (int i = NUM_SRC - 1; i >= 0; i--) begin
                        if (ready[i]) begin
                            sel_d  = SEL_W'(i);
                            intr_d = NUM_SRC'(1) << i;
                        end
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                // Looking at the next mask value lets a withdrawal drop the line on the write edge.
                if (bus.int_taken) begin
                    take_clr = NUM_SRC'(1) << sel_q;
                    insvc_d  = insvc_q | take_clr;
                    intr_d   = '0;
                    state_d  = SVC;
                end else if (!mask_d[sel_q]) begin
                    intr_d  = '0;
                    state_d = IDLE;
                end
            end
            SVC: begin
                if (bus.int_eret) begin
                    insvc_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            insvc_q   <= '0;
            intr_q    <= '0;
            sel_q     <= '0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= bus.irq_src;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            insvc_q   <= insvc_d;
            intr_q    <= intr_d;
            sel_q     <= sel_d;
            state_q   <= state_d;
        end
    end

`ifdef INTC_LOST_CNT_EN
    localparam int LOST_N = (NUM_SRC < 4) ? NUM_SRC : 4;

    logic [7:0] lost_q [NUM_SRC];
    logic [7:0] lost_d [NUM_SRC];
    logic       wr_lost;

    assign wr_lost = bus.io_wr && (bus.io_addr == ADDR_LOST);

    // A clear that coincides with a lost event leaves that one event counted.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            lost_d[i] = lost_q[i];
            if (wr_lost) begin
                lost_d[i] = 8'(edge_evt[i] && pending_q[i]);
            end else if (edge_evt[i] && pending_q[i] && (lost_q[i] != 8'hFF)) begin
                lost_d[i] = lost_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reset) lost_q[i] <= '0;
            else       lost_q[i] <= lost_d[i];
        end
    end

    always_comb begin
        lost_rdata = '0;
        for (int i = 0; i < LOST_N; i++) begin
            lost_rdata[8*i +: 8] = lost_q[i];
        end
    end
`else
    assign lost_rdata = '0;
`endif

    always_comb begin
        bus.io_rdata = '0;
        case (bus.io_addr)
            ADDR_PENDING: bus.io_rdata[NUM_SRC-1:0] = pending_q;
            ADDR_MASK:    bus.io_rdata[NUM_SRC-1:0] = mask_q;
            ADDR_INSVC:   bus.io_rdata[NUM_SRC-1:0] = insvc_q;
            ADDR_LOST:    bus.io_rdata = lost_rdata;
            default:      bus.io_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a randomized
// run against a behavioural model. Define INTC_LOST_CNT_EN to exercise the lost counters.
module tb_interrupt_controller;
    localparam int NUM_SRC = 2;
    localparam int AW      = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    logic clock = 1'b0;
    logic reset;
    int   nVectors     = 0;
    int   nMiscompares = 0;

    interrupt_controller_if #(.NUM_SRC(NUM_SRC), .AW(AW)) bus ();

    interrupt_controller #(.NUM_SRC(NUM_SRC), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        bus.irq_src   = '0;
        bus.int_taken = 1'b0;
        bus.int_eret  = 1'b0;
        bus.io_addr   = '0;
        bus.io_wr     = 1'b0;
        bus.io_rd     = 1'b0;
        bus.io_wdata  = '0;
    endtask

    task automatic readReg(input logic [AW-1:0] addr, output logic [31:0] data);
        bus.io_addr = addr;
        bus.io_rd   = 1'b1;
        #1;
        data      = bus.io_rdata;
        bus.io_rd = 1'b0;
    endtask

    task automatic writeReg(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_wr    = 1'b1;
        step();
        bus.io_wr    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        idleInputs();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        nVectors++;
        if (bus.intr_out !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL reset_intr: got %b expected 00", bus.intr_out);
        end
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_pending: got %h expected 00000000", d);
        end
        readReg(4'h4, d);
        nVectors++;
        if (d !== 32'h3) begin
            nMiscompares++;
            $display("[TB] FAIL reset_mask: got %h expected 00000003", d);
        end
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_insvc: got %h expected 00000000", d);
        end
        readReg(4'hC, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_lost: got %h expected 00000000", d);
        end
    endtask

    task automatic test_latency();
        logic [31:0] d;
        bus.irq_src[0] = 1'b1;
        step(2);
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL lat_pending_early: got %h expected 00000000", d);
        end
        step();
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h1 || bus.intr_out !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL lat_pending: got %h/%b expected 00000001/00", d, bus.intr_out);
        end
        step();
        nVectors++;
        if (bus.intr_out !== 2'b01) begin
            nMiscompares++;
            $display("[TB] FAIL lat_intr: got %b expected 01", bus.intr_out);
        end
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h1) begin
            nMiscompares++;
            $display("[TB] FAIL lat_insvc: got %h expected 00000001", d);
        end
        bus.int_eret = 1'b1;
        step();
        bus.int_eret = 1'b0;
        bus.irq_src  = '0;
        step(3);
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus.irq_src = 2'b11;
        step(4);
        nVectors++;
        if (bus.intr_out !== 2'b01) begin
            nMiscompares++;
            $display("[TB] FAIL prio_intr: got %b expected 01", bus.intr_out);
        end
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h1) begin
            nMiscompares++;
            $display("[TB] FAIL prio_insvc: got %h expected 00000001", d);
        end
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h2 || bus.intr_out !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL prio_pending: got %h/%b expected 00000002/00", d, bus.intr_out);
        end
        bus.int_eret = 1'b1;
        step();
        bus.int_eret = 1'b0;
        step();
        nVectors++;
        if (bus.intr_out !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL prio_second: got %b expected 10", bus.intr_out);
        end
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        bus.int_eret  = 1'b1;
        step();
        bus.int_eret  = 1'b0;
        bus.irq_src   = '0;
        step(3);
    endtask

    task automatic test_mask_enable();
        logic [31:0] d;
        writeReg(4'h4, 32'h2);
        bus.irq_src[0] = 1'b1;
        step(5);
        readReg(4'h0, d);
        nVectors++;
        if (bus.intr_out !== 2'b00 || d !== 32'h1) begin
            nMiscompares++;
            $display("[TB] FAIL mask_block: got %b/%h expected 00/00000001", bus.intr_out, d);
        end
        writeReg(4'h4, 32'h3);
        step();
        nVectors++;
        if (bus.intr_out !== 2'b01) begin
            nMiscompares++;
            $display("[TB] FAIL mask_enable: got %b expected 01", bus.intr_out);
        end
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        bus.int_eret  = 1'b1;
        step();
        bus.int_eret  = 1'b0;
        bus.irq_src   = '0;
        step(3);
    endtask

    task automatic test_mask_withdraw();
        logic [31:0] d;
        bus.irq_src[1] = 1'b1;
        step(4);
        nVectors++;
        if (bus.intr_out !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL withdraw_req: got %b expected 10", bus.intr_out);
        end
        writeReg(4'h4, 32'h1);
        readReg(4'h0, d);
        nVectors++;
        if (bus.intr_out !== 2'b00 || d !== 32'h2) begin
            nMiscompares++;
            $display("[TB] FAIL withdraw_drop: got %b/%h expected 00/00000002", bus.intr_out, d);
        end
        writeReg(4'h4, 32'h3);
        step();
        nVectors++;
        if (bus.intr_out !== 2'b10) begin
            nMiscompares++;
            $display("[TB] FAIL withdraw_rereq: got %b expected 10", bus.intr_out);
        end
        // Taken and a masking write in the same cycle: the take must stick.
        bus.int_taken = 1'b1;
        writeReg(4'h4, 32'h1);
        bus.int_taken = 1'b0;
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h2 || bus.intr_out !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL taken_vs_mask: got %h/%b expected 00000002/00", d, bus.intr_out);
        end
        bus.int_eret = 1'b1;
        step();
        bus.int_eret = 1'b0;
        writeReg(4'h4, 32'h3);
        bus.irq_src = '0;
        step(3);
    endtask

    task automatic test_w1c_and_reset();
        logic [31:0] d;
        writeReg(4'h4, 32'h0);
        bus.irq_src[0] = 1'b1;
        step(3);
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h1) begin
            nMiscompares++;
            $display("[TB] FAIL w1c_setup: got %h expected 00000001", d);
        end
        bus.irq_src[0] = 1'b0;
        step(2);
        bus.irq_src[0] = 1'b1;
        step(2);
        writeReg(4'h0, 32'h1);
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h1) begin
            nMiscompares++;
            $display("[TB] FAIL w1c_set_wins: got %h expected 00000001", d);
        end
        writeReg(4'h0, 32'h1);
        readReg(4'h0, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL w1c_clear: got %h expected 00000000", d);
        end
        bus.irq_src = '0;
        writeReg(4'h4, 32'h3);
        bus.irq_src[1] = 1'b1;
        step(4);
        bus.int_taken = 1'b1;
        step();
        bus.int_taken = 1'b0;
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h2) begin
            nMiscompares++;
            $display("[TB] FAIL svc_entry: got %h expected 00000002", d);
        end
        writeReg(4'h4, 32'h1);
        reset       = 1'b1;
        bus.irq_src = '0;
        step();
        reset = 1'b0;
        readReg(4'h8, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL svc_reset_insvc: got %h expected 00000000", d);
        end
        readReg(4'h4, d);
        nVectors++;
        if (d !== 32'h3 || bus.intr_out !== 2'b00) begin
            nMiscompares++;
            $display("[TB] FAIL svc_reset_mask: got %h/%b expected 00000003/00", d, bus.intr_out);
        end
        step(3);
    endtask

    task automatic test_lost();
        logic [31:0] d;
`ifdef INTC_LOST_CNT_EN
        writeReg(4'h4, 32'h0);
        for (int i = 0; i < 300; i++) begin
            bus.irq_src[1] = 1'b1;
            step();
            bus.irq_src[1] = 1'b0;
            step();
        end
        step(3);
        readReg(4'hC, d);
        nVectors++;
        if (d !== 32'h0000_FF00) begin
            nMiscompares++;
            $display("[TB] FAIL lost_saturate: got %h expected 0000ff00", d);
        end
        writeReg(4'hC, 32'h0);
        readReg(4'hC, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL lost_clear: got %h expected 00000000", d);
        end
        writeReg(4'h0, 32'h3);
        writeReg(4'h4, 32'h3);
`else
        writeReg(4'hC, 32'hFFFF_FFFF);
        readReg(4'hC, d);
        nVectors++;
        if (d !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL lost_absent: got %h expected 00000000", d);
        end
`endif
        writeReg(4'h5, 32'h0);
        readReg(4'h4, d);
        nVectors++;
        if (d !== 32'h3) begin
            nMiscompares++;
            $display("[TB] FAIL unmapped_write: got %h expected 00000003", d);
        end
    endtask

    // Randomized run; the model tracks register contents and request phase from the
    // behavioural rules, with a sampled-level delay line standing in for the input path.
    task automatic test_random();
        logic [1:0]    lvlNow, lvl1, lvl2, lvl3, edgeNow, clrBits, newMask;
        logic [1:0]    mPend, mMask, mInsvc, mIntr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata, expRd;
        logic          taken, eret, wr;
        int            mPhase, mSel;
        int            lostCnt [2];

        idleInputs();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        lvlNow = '0; lvl1 = '0; lvl2 = '0; lvl3 = '0;
        mPend = '0; mMask = 2'b11; mInsvc = '0; mIntr = '0;
        mPhase = PH_IDLE; mSel = 0;
        lostCnt[0] = 0; lostCnt[1] = 0;

        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 3) == 0) lvlNow[b] = ~lvlNow[b];
            end
            taken = ($urandom_range(0, 9) < 3);
            eret  = ($urandom_range(0, 9) < 2);
            wr    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) addr = AW'($urandom_range(0, 15));
            else                           addr = AW'($urandom_range(0, 3) * 4);
            wdata = $urandom;

            bus.irq_src   = lvlNow;
            bus.int_taken = taken;
            bus.int_eret  = eret;
            bus.io_wr     = wr;
            bus.io_addr   = addr;
            bus.io_wdata  = wdata;
            #1;

            case (addr)
                4'h0: expRd = {30'b0, mPend};
                4'h4: expRd = {30'b0, mMask};
                4'h8: expRd = {30'b0, mInsvc};
`ifdef INTC_LOST_CNT_EN
                4'hC: expRd = {16'b0, 8'(lostCnt[1]), 8'(lostCnt[0])};
`endif
                default: expRd = 32'h0;
            endcase
            nVectors++;
            if (bus.intr_out !== mIntr) begin
                nMiscompares++;
                $display("[TB] FAIL rand_intr cycle %0d: got %b expected %b", c, bus.intr_out, mIntr);
            end
            nVectors++;
            if (bus.io_rdata !== expRd) begin
                nMiscompares++;
                $display("[TB] FAIL rand_rdata cycle %0d addr %h: got %h expected %h", c, addr, bus.io_rdata, expRd);
            end

            edgeNow = lvl2 & ~lvl3;
            clrBits = '0;
            newMask = mMask;
            if (wr && addr == 4'h0) clrBits = wdata[1:0];
            if (wr && addr == 4'h4) newMask = wdata[1:0];
            if (mPhase == PH_IDLE) begin
                if ((mPend & mMask) != 2'b00) begin
                    mSel   = (mPend[0] && mMask[0]) ? 0 : 1;
                    mIntr  = 2'b01 << mSel;
                    mPhase = PH_REQ;
                end
            end else if (mPhase == PH_REQ) begin
                if (taken) begin
                    clrBits = clrBits | (2'b01 << mSel);
                    mInsvc  = mInsvc | (2'b01 << mSel);
                    mIntr   = '0;
                    mPhase  = PH_SVC;
                end else if (!newMask[mSel]) begin
                    mIntr  = '0;
                    mPhase = PH_IDLE;
                end
            end else if (eret) begin
                mInsvc = '0;
                mPhase = PH_IDLE;
            end
            for (int b = 0; b < 2; b++) begin
                if (wr && addr == 4'hC)          lostCnt[b] = (edgeNow[b] && mPend[b]) ? 1 : 0;
                else if (edgeNow[b] && mPend[b]) lostCnt[b] = (lostCnt[b] < 255) ? lostCnt[b] + 1 : 255;
            end
            mPend = (mPend & ~clrBits) | edgeNow;
            mMask = newMask;

            step();
            lvl3 = lvl2;
            lvl2 = lvl1;
            lvl1 = lvlNow;
        end
        idleInputs();
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        test_reset();
        step(5);
        test_latency();
        test_priority();
        test_mask_enable();
        test_mask_withdraw();
        test_w1c_and_reset();
        test_lost();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
